// File: rtl/linebuf_pkg.sv
// linebuf_pkg: shared FSM states and priming depth for the 3-row line buffer sequencer
package linebuf_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  localparam int PRIME_ROWS = 2;
endpackage

// File: rtl/pix_xy_counter.sv
// pix_xy_counter: raster x/y counter; i_adv accepts a pixel, i_restart makes it (0,0), o_x/o_y/o_last describe that pixel
module pix_xy_counter #(
  parameter int P_ROW_WIDTH  = 256,
  parameter int P_COL_HEIGHT = 256,
  parameter int P_ADDR_WIDTH = 12
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_adv,
  input  logic                    i_restart,
  output logic [P_ADDR_WIDTH-1:0] o_x,
  output logic [P_ADDR_WIDTH-1:0] o_y,
  output logic                    o_last
);
  logic [P_ADDR_WIDTH-1:0] r_x, r_y;
  logic                    w_eol;
  always_comb begin
    o_x    = i_restart ? '0 : r_x;
    o_y    = i_restart ? '0 : r_y;
    w_eol  = o_x == P_ADDR_WIDTH'(P_ROW_WIDTH - 1);
    o_last = w_eol && o_y == P_ADDR_WIDTH'(P_COL_HEIGHT - 1);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_adv) begin
      r_x <= w_eol ? '0 : o_x + 1'b1;
      r_y <= o_last ? '0 : o_y + P_ADDR_WIDTH'(w_eol);
    end
endmodule

// File: rtl/linebuf_3row_ctrl.sv
// linebuf_3row_ctrl: pixel stream in (i_pix_*, i_sof), row RAM ports out (a=write, b=read), aligned 3-row column + tags out (o_col_*, o_row_*, o_frame_done, o_busy)
import linebuf_pkg::*;
module linebuf_3row_ctrl #(
  parameter int P_ROW_WIDTH  = 256,
  parameter int P_COL_HEIGHT = 256,
  parameter int P_DATA_WIDTH = 8,
  parameter int P_ADDR_WIDTH = 12
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_pix_valid,
  input  logic [P_DATA_WIDTH-1:0] i_pix_data,
  input  logic                    i_sof,
  output logic [P_ADDR_WIDTH-1:0] o_addra1,
  output logic [P_ADDR_WIDTH-1:0] o_addra2,
  output logic                    o_wea1,
  output logic                    o_wea2,
  output logic [P_DATA_WIDTH-1:0] o_dina1,
  output logic [P_DATA_WIDTH-1:0] o_dina2,
  output logic [P_ADDR_WIDTH-1:0] o_addrb1,
  output logic [P_ADDR_WIDTH-1:0] o_addrb2,
  output logic                    o_enb1,
  output logic                    o_enb2,
  input  logic [P_DATA_WIDTH-1:0] i_doutb1,
  input  logic [P_DATA_WIDTH-1:0] i_doutb2,
  output logic                    o_col_valid,
  output logic [P_DATA_WIDTH-1:0] o_row_top,
  output logic [P_DATA_WIDTH-1:0] o_row_mid,
  output logic [P_DATA_WIDTH-1:0] o_row_bot,
  output logic [P_ADDR_WIDTH-1:0] o_col_x,
  output logic [P_ADDR_WIDTH-1:0] o_col_y,
  output logic                    o_frame_done,
  output logic                    o_busy
);
  state_t                  r_state, w_state_nxt;
  logic                    w_acc, w_restart, w_last;
  logic [P_ADDR_WIDTH-1:0] w_x, w_y, r_x, r_y;
  logic [P_DATA_WIDTH-1:0] r_pix;
  logic                    r_v, r_last;
  assign w_acc     = i_rst_n && i_pix_valid && (r_state != IDLE || i_sof);
  assign w_restart = w_acc && i_sof;
  pix_xy_counter #(
    .P_ROW_WIDTH (P_ROW_WIDTH),
    .P_COL_HEIGHT(P_COL_HEIGHT),
    .P_ADDR_WIDTH(P_ADDR_WIDTH)
  ) u_xy (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_adv    (w_acc),
    .i_restart(w_restart),
    .o_x      (w_x),
    .o_y      (w_y),
    .o_last   (w_last)
  );
  always_comb begin
    w_state_nxt = r_state;
    if (w_restart)
      w_state_nxt = PRIME;
    else if (w_acc && r_state == PRIME && w_y == P_ADDR_WIDTH'(PRIME_ROWS - 1) &&
             w_x == P_ADDR_WIDTH'(P_ROW_WIDTH - 1))
      w_state_nxt = RUN;
    else if (w_acc && w_last)
      w_state_nxt = IDLE;
    o_enb1       = w_acc;
    o_enb2       = w_acc;
    o_addrb1     = w_acc ? w_x : '0;
    o_addrb2     = w_acc ? w_x : '0;
    o_wea1       = r_v;
    o_wea2       = r_v;
    o_addra1     = r_v ? r_x : '0;
    o_addra2     = r_v ? r_x : '0;
    o_dina1      = r_v ? i_doutb2 : '0;
    o_dina2      = r_v ? r_pix : '0;
    o_col_valid  = r_v && r_y >= P_ADDR_WIDTH'(PRIME_ROWS);
    o_row_top    = r_v ? i_doutb1 : '0;
    o_row_mid    = r_v ? i_doutb2 : '0;
    o_row_bot    = r_v ? r_pix : '0;
    o_col_x      = r_x;
    o_col_y      = r_y;
    o_frame_done = r_v && r_last;
    // a sof accepted straight out of IDLE keeps busy high across back-to-back frames
    o_busy       = r_state != IDLE || w_restart;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_v     <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_pix   <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_v     <= w_acc;
      if (w_acc) begin
        r_x    <= w_x;
        r_y    <= w_y;
        r_pix  <= i_pix_data;
        r_last <= w_last;
      end
    end
endmodule

// File: doc/linebuf_3row_ctrl.md
# linebuf_3row_ctrl

Sequencer for the two-row true-dual-port line-buffer pair used by the 3x3 neighbourhood filters in the infrared pipeline. It accepts a raster pixel stream, generates addresses and enables for both row RAMs, and shifts row data through them: row RAM 2 holds row y-1 and row RAM 1 holds row y-2. Each accepted pixel produces one aligned three-row column (top/mid/bottom) for the downstream window builder, with frame priming, position tags and end-of-frame signalling.

## Interface
- P_ROW_WIDTH, 256: pixels per row (RAM depth used).
- P_COL_HEIGHT, 256: rows per frame (minimum 3).
- P_DATA_WIDTH, 8: pixel width.
- P_ADDR_WIDTH, 12: RAM address width; must satisfy 2^P_ADDR_WIDTH >= P_ROW_WIDTH.
- Clocking: one clock, `i_clk`. Reset `i_rst_n` is asynchronous and active-low.
- i_clk  in  1  system clock; the row RAMs run on the same clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_pix_valid  in  1  input pixel strobe; no backpressure.
- i_pix_data  in  P_DATA_WIDTH  input pixel.
- i_sof  in  1  start of frame; qualified by i_pix_valid and marks pixel (0,0).
- o_addra1, o_addra2  out  P_ADDR_WIDTH  RAM write addresses.
- o_wea1, o_wea2  out  1  RAM write enables.
- o_dina1, o_dina2  out  P_DATA_WIDTH  RAM write data.
- o_addrb1, o_addrb2  out  P_ADDR_WIDTH  RAM read addresses.
- o_enb1, o_enb2  out  1  RAM read enables.
- i_doutb1, i_doutb2  in  P_DATA_WIDTH  RAM read data; 1-cycle read latency.
- o_col_valid  out  1  column output valid.
- o_row_top, o_row_mid, o_row_bot  out  P_DATA_WIDTH  pixels from rows y-2, y-1 and y.
- o_col_x, o_col_y  out  P_ADDR_WIDTH  position of o_row_bot.
- o_frame_done  out  1  one-cycle pulse when the last column of a frame is output.
- o_busy  out  1  high when the FSM is in any state other than IDLE.

## Operation
- FSM states: IDLE, PRIME, RUN.
  - IDLE -> PRIME on i_pix_valid & i_sof.
  - PRIME -> RUN when y advances from 1 to 2.
  - RUN -> IDLE after the pixel at (P_ROW_WIDTH-1, P_COL_HEIGHT-1).
- Counters: x runs 0..P_ROW_WIDTH-1 and wraps to 0 with y+1; y runs 0..P_COL_HEIGHT-1. Counters advance only on accepted pixels.
- Accepted pixel: i_pix_valid in PRIME/RUN, or the sof pixel in IDLE. Pixels without sof in IDLE are dropped; counters and RAM ports stay idle.
- i_sof on an accepted pixel in PRIME or RUN restarts the frame: x=0, y=0, state PRIME, and that pixel is pixel (0,0). No o_frame_done is issued for the aborted frame. Stale RAM contents are overwritten before they are exposed.
- Cycle t, accepted pixel at x: o_enb1 = o_enb2 = 1 and o_addrb1 = o_addrb2 = x. The pixel and x are registered.
- Cycle t+1, shift write: o_wea1 = 1 with o_addra1 = x and o_dina1 = i_doutb2; o_wea2 = 1 with o_addra2 = x and o_dina2 = the registered pixel.
- Cycle t+1, column output: o_row_top = i_doutb1, o_row_mid = i_doutb2, o_row_bot = the registered pixel. o_col_valid = 1 only if that pixel's y >= 2.
- A write at t+1 to address x never collides with the read at t+1, because that read targets x+1 or is idle.
- In PRIME, rows 0 and 1 are written and read, but o_col_valid stays 0.

## Timing
- Reset values: all outputs 0; state IDLE; x = y = 0.
- Latency: pixel in at cycle t → column out at t+1 → RAM write at t+1. Full throughput of one pixel per cycle; gaps are allowed anywhere.
- o_frame_done is asserted in the same cycle as the o_col_valid of pixel (P_ROW_WIDTH-1, P_COL_HEIGHT-1). o_busy drops in that same cycle.
- A new i_sof in the cycle immediately after the last pixel is accepted normally, with no lost cycles.
- Reset asserted mid-frame: all outputs clear immediately and any pending t+1 write is discarded.

## Structure
- Package linebuf_pkg holds the state enum (IDLE/PRIME/RUN) and the constant PRIME_ROWS = 2.
- One sub-module, pix_xy_counter, holds the x/y raster counter with wrap and last-pixel flag.
- The two row RAMs are instantiated by the parent and are not part of this block.

## Test plan
- Bench parameters: P_ROW_WIDTH=4, P_COL_HEIGHT=4; pixel value = 16*y + x.
- Back-to-back frame: o_col_valid fires 8 times. The first valid column is top/mid/bot = 0x00/0x10/0x20 at (0,2). The last is 0x13/0x23/0x33 at (3,3), with o_frame_done on the same cycle.
- Random i_pix_valid gaps, same frame: identical column sequence. Each column appears exactly 1 cycle after its pixel.
- i_sof issued at pixel (2,2): the aborted frame produces no o_frame_done. The restarted frame yields first column 0x00/0x10/0x20 at (0,2).
- Pixels with i_pix_valid=1 and i_sof=0 while in IDLE: no RAM enables and o_busy=0.
- Reset asserted at y=3: all outputs read 0 immediately. A subsequent sof frame completes correctly.
- Last pixel immediately followed by a new sof pixel: o_frame_done pulses once, o_busy stays 1, and the second frame's output is correct.
